// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - pipeline stall/flush/redirect controller with memory-wait timeout
// Arbitrates trap, data stall, branch, load-use and fetch stall into per-stage enables and flushes.
module hazard_control_unit #(
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       inst_mem_ack,
  input  logic       data_mem_req,
  input  logic       data_mem_ack,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_mem_read,
  input  logic       branch_taken,
  input  logic       trap,
  output logic       pc_en,
  output logic       if_id_en,
  output logic       id_ex_en,
  output logic       ex_mem_en,
  output logic       mem_wb_en,
  output logic       if_id_flush,
  output logic       id_ex_flush,
  output logic       ex_mem_flush,
  output logic       mem_wb_flush,
  output logic       inst_mem_req,
  output logic       bus_error
);

  typedef enum logic [1:0] {
    ST_FLUSH,
    ST_RUN,
    ST_DMEM_WAIT,
    ST_HALT
  } state_e;

  localparam logic [8:0] TimeoutLimit = 9'(TimeoutCycles);

  state_e     state_q, state_d;
  logic       discard_q, discard_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;

  logic active;
  logic data_blocked;
  logic trap_now;
  logic stall_now;
  logic load_use;
  logic redirect;
  logic wait_inc;
  logic timeout;

  assign active = (state_q == ST_RUN) || (state_q == ST_DMEM_WAIT);

  // Once in DMEM_WAIT only the ack matters; EX/MEM is frozen so the request is implied.
  assign data_blocked = (state_q == ST_DMEM_WAIT) ? !data_mem_ack
                      : ((state_q == ST_RUN) && data_mem_req && !data_mem_ack);

  assign trap_now  = active && trap && !((state_q == ST_DMEM_WAIT) && data_blocked);
  assign stall_now = data_blocked && !trap_now;
  assign load_use  = ex_mem_read && (ex_rd != 5'd0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
  assign redirect  = trap_now || (active && !data_blocked && branch_taken);

  // A pending data access dominates; otherwise any ack ends the wait.
  assign wait_inc = active && (data_blocked || (!inst_mem_ack && !data_mem_ack));
  assign timeout  = wait_inc && (({1'b0, wait_cnt_q} + 9'd1) >= TimeoutLimit);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_FLUSH;
      discard_q  <= 1'b0;
      wait_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      discard_q  <= discard_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    discard_d  = discard_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      ST_FLUSH: begin
        state_d    = ST_RUN;
        wait_cnt_d = 8'd0;
      end
      ST_RUN, ST_DMEM_WAIT: begin
        wait_cnt_d = wait_inc ? (wait_cnt_q + 8'd1) : 8'd0;
        if (redirect && !inst_mem_ack) begin
          discard_d = 1'b1;
        end else if (inst_mem_ack) begin
          discard_d = 1'b0;
        end
        if (timeout) begin
          state_d = ST_HALT;
        end else if (stall_now) begin
          state_d = ST_DMEM_WAIT;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FLUSH;
    endcase
  end

  always_comb begin
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    id_ex_en     = 1'b0;
    ex_mem_en    = 1'b0;
    mem_wb_en    = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    inst_mem_req = 1'b0;
    bus_error    = 1'b0;
    if (reset || (state_q == ST_FLUSH)) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (state_q == ST_HALT) begin
      bus_error = 1'b1;
    end else begin
      pc_en        = 1'b1;
      if_id_en     = 1'b1;
      id_ex_en     = 1'b1;
      ex_mem_en    = 1'b1;
      mem_wb_en    = 1'b1;
      inst_mem_req = 1'b1;
      if (trap_now) begin
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        ex_mem_flush = 1'b1;
      end else if (stall_now) begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_en     = 1'b0;
        ex_mem_en    = 1'b0;
        mem_wb_flush = 1'b1;
      end else if (branch_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end else if (!inst_mem_ack) begin
        pc_en       = 1'b0;
        if_id_flush = 1'b1;
      end else if (discard_q) begin
        // Stale response from the pre-redirect fetch: drop it, keep fetching.
        if_id_flush = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb/tb_hazard_control_unit.sv - self-checking bench for hazard_control_unit
// Action-level reference model checked every cycle, plus directed literal expectations.
module tb_hazard_control_unit;

  localparam int T = 4;

  logic       clock = 1'b0;
  logic       reset, inst_mem_ack, data_mem_req, data_mem_ack;
  logic       ex_mem_read, branch_taken, trap;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic       if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic       inst_mem_req, bus_error;

  always #5 clock = ~clock;

  hazard_control_unit #(.TimeoutCycles(T)) dut (
    .clock(clock), .reset(reset), .inst_mem_ack(inst_mem_ack),
    .data_mem_req(data_mem_req), .data_mem_ack(data_mem_ack),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .branch_taken(branch_taken), .trap(trap),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
    .inst_mem_req(inst_mem_req), .bus_error(bus_error)
  );

  wire [10:0] dut_vec = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                         if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
                         inst_mem_req, bus_error};

  // {pc,if_id,id_ex,ex_mem,mem_wb enables | four flushes | inst_mem_req | bus_error}
  localparam logic [10:0] P_FLUSH = 11'b00000_1111_0_0;
  localparam logic [10:0] P_RUN   = 11'b11111_0000_1_0;
  localparam logic [10:0] P_TRAP  = 11'b11111_1110_1_0;
  localparam logic [10:0] P_DS    = 11'b00001_0001_1_0;
  localparam logic [10:0] P_BR    = 11'b11111_1100_1_0;
  localparam logic [10:0] P_LU    = 11'b00111_0100_1_0;
  localparam logic [10:0] P_FS    = 11'b01111_1000_1_0;
  localparam logic [10:0] P_DROP  = 11'b11111_1000_1_0;
  localparam logic [10:0] P_HALT  = 11'b00000_0000_0_1;

  localparam int A_FLUSH = 0, A_RUN = 1, A_TRAP = 2, A_DSTALL = 3, A_BRANCH = 4;
  localparam int A_LOADUSE = 5, A_FSTALL = 6, A_DROP = 7, A_HALT = 8;
  localparam int M_FLUSH = 0, M_RUN = 1, M_WAIT = 2, M_HALT = 3;

  int  m_mode = M_FLUSH;
  bit  m_disc = 1'b0;
  int  m_wait = 0;
  int  checks = 0;
  int  failures = 0;
  bit  compare_en = 1'b0;

  function automatic logic [10:0] pattern(input int act);
    case (act)
      A_FLUSH:   return P_FLUSH;
      A_RUN:     return P_RUN;
      A_TRAP:    return P_TRAP;
      A_DSTALL:  return P_DS;
      A_BRANCH:  return P_BR;
      A_LOADUSE: return P_LU;
      A_FSTALL:  return P_FS;
      A_DROP:    return P_DROP;
      default:   return P_HALT;
    endcase
  endfunction

  function automatic bit data_pending();
    if (m_mode == M_WAIT) return !data_mem_ack;
    return (m_mode == M_RUN) && data_mem_req && !data_mem_ack;
  endfunction

  function automatic bit waiting();
    return data_pending() || (!inst_mem_ack && !data_mem_ack);
  endfunction

  function automatic int decide();
    if (reset || m_mode == M_FLUSH) return A_FLUSH;
    if (m_mode == M_HALT) return A_HALT;
    if (m_mode == M_RUN && trap) return A_TRAP;
    if (data_pending()) return A_DSTALL;
    if (trap) return A_TRAP;
    if (branch_taken) return A_BRANCH;
    if (ex_mem_read && ex_rd != 5'd0 && (ex_rd == id_rs1 || ex_rd == id_rs2)) return A_LOADUSE;
    if (!inst_mem_ack) return A_FSTALL;
    if (m_disc) return A_DROP;
    return A_RUN;
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      m_mode <= M_FLUSH;
      m_disc <= 1'b0;
      m_wait <= 0;
    end else if (m_mode == M_FLUSH) begin
      m_mode <= M_RUN;
      m_wait <= 0;
    end else if (m_mode != M_HALT) begin
      m_wait <= waiting() ? m_wait + 1 : 0;
      if (waiting() && (m_wait + 1 >= T)) m_mode <= M_HALT;
      else if (decide() == A_DSTALL) m_mode <= M_WAIT;
      else m_mode <= M_RUN;
      if ((decide() == A_TRAP || decide() == A_BRANCH) && !inst_mem_ack) m_disc <= 1'b1;
      else if (inst_mem_ack) m_disc <= 1'b0;
    end
  end

  always @(negedge clock) begin
    if (compare_en) begin
      checks++;
      if (dut_vec !== pattern(decide())) begin
        failures++;
        $display("FAIL model_outputs t=%0t act=%0d got=%b want=%b", $time, decide(), dut_vec, pattern(decide()));
      end
      checks++;
      if (dut.wait_cnt_q !== 8'(m_wait)) begin
        failures++;
        $display("FAIL model_wait_cnt t=%0t got=%0d want=%0d", $time, dut.wait_cnt_q, m_wait);
      end
      checks++;
      if (dut.discard_q !== m_disc) begin
        failures++;
        $display("FAIL model_discard t=%0t got=%0b want=%0b", $time, dut.discard_q, m_disc);
      end
    end
  end

  task automatic lit(input string name, input logic [10:0] want);
    @(negedge clock);
    checks++;
    if (dut_vec !== want) begin
      failures++;
      $display("FAIL %s got=%b want=%b", name, dut_vec, want);
    end
  endtask

  task automatic lit_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic drive(input bit r, input bit ia, input bit dr, input bit da,
                       input bit br, input bit tr, input bit mr,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    @(posedge clock);
    #1;
    reset = r; inst_mem_ack = ia; data_mem_req = dr; data_mem_ack = da;
    branch_taken = br; trap = tr; ex_mem_read = mr;
    ex_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
  endtask

  task automatic plain(input bit ia);
    drive(1'b0, ia, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3, 5'd1, 5'd2);
  endtask

  task automatic dstall(input bit da, input bit br, input bit tr);
    drive(1'b0, 1'b1, 1'b1, da, br, tr, 1'b0, 5'd3, 5'd1, 5'd2);
  endtask

  initial begin
    reset = 1'b1; inst_mem_ack = 1'b1; data_mem_req = 1'b0; data_mem_ack = 1'b0;
    branch_taken = 1'b0; trap = 1'b0; ex_mem_read = 1'b0;
    ex_rd = 5'd3; id_rs1 = 5'd1; id_rs2 = 5'd2;
    @(posedge clock);
    #1;
    compare_en = 1'b1;
    lit("reset_outputs", P_FLUSH);
    plain(1'b1); lit("flush_after_release", P_FLUSH);
    plain(1'b1); lit("run_baseline", P_RUN);

    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd1, 5'd5); lit("load_use_rs2", P_LU);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0); lit("load_use_rd0", P_RUN);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 5'd7, 5'd2); lit("load_use_rs1", P_LU);

    dstall(1'b0, 1'b0, 1'b0); lit("dstall_1", P_DS);
    dstall(1'b0, 1'b1, 1'b0); lit("dstall_2_branch_ignored", P_DS);
    dstall(1'b0, 1'b0, 1'b1); lit("dstall_3_trap_deferred", P_DS);
    dstall(1'b1, 1'b0, 1'b0); lit("dstall_ack", P_RUN);
    lit_int("wait_cnt_after_3", int'(dut.wait_cnt_q), 3);
    plain(1'b1); lit("after_ack", P_RUN);
    lit_int("wait_cnt_cleared", int'(dut.wait_cnt_q), 0);

    dstall(1'b0, 1'b0, 1'b0); lit("dstall_then_trap", P_DS);
    dstall(1'b1, 1'b0, 1'b1); lit("trap_on_ack", P_TRAP);

    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd3, 5'd1, 5'd2); lit("branch_fetch_miss", P_BR);
    plain(1'b0); lit("fetch_wait", P_FS);
    lit_int("discard_set", int'(dut.discard_q), 1);
    plain(1'b1); lit("stale_drop", P_DROP);
    plain(1'b1); lit("post_drop", P_RUN);
    lit_int("discard_cleared", int'(dut.discard_q), 0);

    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd5, 5'd1, 5'd5); lit("trap_over_all", P_TRAP);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd3, 5'd1, 5'd2); lit("trap_fetch_miss", P_TRAP);
    plain(1'b1); lit("trap_drop", P_DROP);
    plain(1'b0); lit("fetch_stall", P_FS);
    plain(1'b1); lit("fetch_resume", P_RUN);

    dstall(1'b0, 1'b0, 1'b0); lit("pre_reset_stall_1", P_DS);
    dstall(1'b0, 1'b0, 1'b0); lit("pre_reset_stall_2", P_DS);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3, 5'd1, 5'd2); lit("reset_mid_stall", P_FLUSH);
    plain(1'b1); lit("flush_after_stall_reset", P_FLUSH);
    plain(1'b1); lit("run_after_stall_reset", P_RUN);

    for (int i = 0; i < T; i++) begin
      dstall(1'b0, 1'b0, 1'b0); lit("timeout_wait", P_DS);
    end
    dstall(1'b1, 1'b0, 1'b0); lit("halt_bus_error", P_HALT);
    plain(1'b1); lit("halt_sticky", P_HALT);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3, 5'd1, 5'd2); lit("reset_in_halt", P_FLUSH);
    plain(1'b1); lit("flush_after_halt", P_FLUSH);
    plain(1'b1); lit("run_after_halt", P_RUN);

    for (int i = 0; i < T; i++) begin
      plain(1'b0); lit("fetch_timeout_wait", P_FS);
    end
    plain(1'b1); lit("fetch_timeout_halt", P_HALT);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3, 5'd1, 5'd2); lit("reset_fetch_halt", P_FLUSH);
    plain(1'b1); lit("final_flush", P_FLUSH);
    plain(1'b1); lit("final_run", P_RUN);

    @(posedge clock);
    #1;
    compare_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_control_unit.md
HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 Parameter TimeoutCycles, default 255, is the number of consecutive unacknowledged memory-wait cycles before a bus error; legal range 1..255.
REQ-002 clock  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high; sampled on the rising edge of clock.
REQ-004 inst_mem_ack  in  1  instruction memory returned the fetch this cycle.
REQ-005 data_mem_req  in  1  EX/MEM mem_read_enable OR mem_write_enable.
REQ-006 data_mem_ack  in  1  data memory completed the access this cycle.
REQ-007 id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
REQ-008 ex_rd  in  5; ex_mem_read  in  1  destination and load flag of the instruction in EX.
REQ-009 branch_taken  in  1  EX resolved a taken branch/jump (PC redirect).
REQ-010 trap  in  1  CSR unit requests a trap redirect.
REQ-011 pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  stage register load enables.
REQ-012 if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1 each  load a bubble (flush wins over enable).
REQ-013 inst_mem_req  out  1  fetch request; bus_error  out  1  sticky timeout flag.

Function
REQ-014 States: FLUSH, RUN, DMEM_WAIT, HALT; state plus the discard_fetch flag and the 8-bit wait_cnt are the only registers; outputs are combinational from state and inputs.
REQ-015 FLUSH: all flushes 1, all enables 0, inst_mem_req 0; always goes to RUN on the next cycle.
REQ-016 RUN baseline: all enables 1, all flushes 0, inst_mem_req 1.
REQ-017 RUN priority, highest first: trap > data stall > branch_taken > load-use > fetch stall.
REQ-018 Trap: pc_en 1; if_id, id_ex, and ex_mem flushed; mem_wb_en 1; discard_fetch set if inst_mem_ack is 0.
REQ-019 Data stall (data_mem_req=1, data_mem_ack=0): pc_en, if_id_en, id_ex_en, and ex_mem_en are 0; mem_wb_flush is 1; next state is DMEM_WAIT.
REQ-020 DMEM_WAIT: same outputs as REQ-019 while ack is 0; on the ack cycle, RUN outputs apply and the next state is RUN.
REQ-021 Branch: pc_en 1; if_id_flush and id_ex_flush 1; discard_fetch set if inst_mem_ack is 0.
REQ-022 Load-use: when ex_mem_read=1, ex_rd!=0, and ex_rd equals id_rs1 or id_rs2, pc_en and if_id_en are 0 and id_ex_flush is 1.
REQ-023 Fetch stall (inst_mem_ack=0): pc_en 0 and if_id_flush 1; downstream stages advance.
REQ-024 When discard_fetch=1 and inst_mem_ack=1, the stale fetch is dropped: if_id_flush 1, pc_en 1, and discard_fetch is cleared.
REQ-025 wait_cnt increments on each cycle with an unacknowledged data or instruction request; it clears on any ack or on a state change to RUN.
REQ-026 When wait_cnt reaches TimeoutCycles, bus_error is set and the next state is HALT.
REQ-027 HALT: all enables 0, all flushes 0, inst_mem_req 0, bus_error 1; HALT is left only by reset.
REQ-028 Trap during DMEM_WAIT is deferred until the ack cycle.
REQ-029 branch_taken is ignored while a data stall is active; EX is frozen and holds the branch.

Reset
REQ-030 While reset=1, outputs equal the FLUSH outputs and bus_error is 0.
REQ-031 While reset=1, wait_cnt and discard_fetch are cleared.
REQ-032 The cycle after reset is released, the state is FLUSH.
REQ-033 Reset asserted mid-stall or in HALT aborts the stall or HALT on the next edge.

Verification
REQ-034 Release reset -> one FLUSH cycle (all flushes 1), then RUN with all enables 1 and inst_mem_req 1.
REQ-035 ex_mem_read=1, ex_rd=5, id_rs2=5 -> pc_en=0, if_id_en=0, id_ex_flush=1 for one cycle; with ex_rd=0 -> no stall.
REQ-036 data_mem_req=1, ack held low for 3 cycles -> 3 frozen cycles, each with mem_wb_flush=1; ack on the 4th cycle -> RUN, wait_cnt=0.
REQ-037 branch_taken with inst_mem_ack=0, ack arriving 2 cycles later -> that fetch dropped (if_id_flush=1, pc_en=1) and discard_fetch cleared.
REQ-038 TimeoutCycles=4, data_mem_ack held 0 -> bus_error=1 after the 4th wait cycle; HALT persists until reset.
REQ-039 trap and branch_taken in the same cycle as load-use -> trap outputs only (ex_mem_flush=1, pc_en=1).
